// File: rtl/powerup_controller.sv
// Power-pack consumer: times respawns, tests ball/pack overlap once per frame,
// and drives the timed effect enables or the one-shot extra-point pulse.
module powerup_controller #(
  parameter int PACK_W         = 20,
  parameter int PACK_H         = 20,
  parameter int BALL_SIZE      = 16,
  parameter int RESPAWN_FRAMES = 180,
  parameter int EFFECT_FRAMES  = 300,
  parameter int SHIELD_FRAMES  = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        round_reset,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic        last_hitter,
  input  logic [10:0] pack_x,
  input  logic [9:0]  pack_y,
  input  logic [1:0]  pack_mode,
  output logic        spawn,
  output logic        eaten,
  output logic [1:0]  effect_mode,
  output logic        effect_player,
  output logic        slow_en,
  output logic        boost_en,
  output logic        shield_en,
  output logic        extra_point,
  output logic [9:0]  frames_left
);

  typedef enum logic [1:0] {S_WAIT, S_SPAWN, S_ARMED, S_EFFECT} state_t;

  localparam logic [1:0] MODE_SLOW   = 2'b00;
  localparam logic [1:0] MODE_BOOST  = 2'b01;
  localparam logic [1:0] MODE_EXTRA  = 2'b10;
  localparam logic [1:0] MODE_SHIELD = 2'b11;

  localparam logic [9:0] RESPAWN_CNT = 10'(RESPAWN_FRAMES);
  localparam logic [9:0] EFFECT_CNT  = 10'(EFFECT_FRAMES);
  localparam logic [9:0] SHIELD_CNT  = 10'(SHIELD_FRAMES);

  state_t     state_q, state_n;
  logic [9:0] count_q, count_n;
  logic       armed_ready_q, armed_ready_n;
  logic       spawn_n, eaten_n, extra_n, slow_n, boost_n, shield_n;
  logic [1:0] mode_n;
  logic       player_n;

  // Widened to 12 bits so pack/ball extents past the screen edge never wrap
  logic [11:0] bx, by, px, py;
  logic        overlap, hit;

  assign bx = {1'b0, ball_x};
  assign by = {2'b00, ball_y};
  assign px = {1'b0, pack_x};
  assign py = {2'b00, pack_y};

  assign overlap = (bx < px + 12'(PACK_W)) && (px < bx + 12'(BALL_SIZE)) &&
                   (by < py + 12'(PACK_H)) && (py < by + 12'(BALL_SIZE));

  // Generator coordinates settle one clock after spawn, so the first ARMED cycle is skipped
  assign hit = (state_q == S_ARMED) && armed_ready_q && frame_tick && overlap;

  assign frames_left = count_q;

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    mode_n   = effect_mode;
    player_n = effect_player;
    spawn_n  = 1'b0;
    eaten_n  = 1'b0;
    extra_n  = 1'b0;
    slow_n   = slow_en;
    boost_n  = boost_en;
    shield_n = shield_en;

    if (round_reset) begin
      state_n  = S_WAIT;
      count_n  = RESPAWN_CNT;
      slow_n   = 1'b0;
      boost_n  = 1'b0;
      shield_n = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (frame_tick) begin
            if (count_q == 10'd1) begin
              state_n = S_SPAWN;
              spawn_n = 1'b1;
            end else begin
              count_n = count_q - 10'd1;
            end
          end
        end
        S_SPAWN: state_n = S_ARMED;
        S_ARMED: begin
          if (hit) begin
            eaten_n  = 1'b1;
            mode_n   = pack_mode;
            player_n = last_hitter;
            case (pack_mode)
              MODE_SLOW:   begin slow_n   = 1'b1; count_n = EFFECT_CNT; state_n = S_EFFECT; end
              MODE_BOOST:  begin boost_n  = 1'b1; count_n = EFFECT_CNT; state_n = S_EFFECT; end
              MODE_SHIELD: begin shield_n = 1'b1; count_n = SHIELD_CNT; state_n = S_EFFECT; end
              MODE_EXTRA:  begin extra_n  = 1'b1; count_n = RESPAWN_CNT; state_n = S_WAIT; end
              default:     state_n = S_ARMED;
            endcase
          end
        end
        S_EFFECT: begin
          if (frame_tick) begin
            if (count_q == 10'd1) begin
              slow_n   = 1'b0;
              boost_n  = 1'b0;
              shield_n = 1'b0;
              count_n  = RESPAWN_CNT;
              state_n  = S_WAIT;
            end else begin
              count_n = count_q - 10'd1;
            end
          end
        end
        default: state_n = S_WAIT;
      endcase
    end

    armed_ready_n = (state_q == S_ARMED) && (state_n == S_ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT;
      count_q       <= RESPAWN_CNT;
      armed_ready_q <= 1'b0;
      spawn         <= 1'b0;
      eaten         <= 1'b0;
      extra_point   <= 1'b0;
      slow_en       <= 1'b0;
      boost_en      <= 1'b0;
      shield_en     <= 1'b0;
      effect_mode   <= 2'b00;
      effect_player <= 1'b0;
    end else begin
      state_q       <= state_n;
      count_q       <= count_n;
      armed_ready_q <= armed_ready_n;
      spawn         <= spawn_n;
      eaten         <= eaten_n;
      extra_point   <= extra_n;
      slow_en       <= slow_n;
      boost_en      <= boost_n;
      shield_en     <= shield_n;
      effect_mode   <= mode_n;
      effect_player <= player_n;
    end
  end

endmodule
